firebird7_in_gate2_ijtag_scan_driver: RTL and testbench

FIREBIRD7_IN_GATE2_IJTAG_SCAN_DRIVER -- requirements
Module: firebird7_in_gate2_ijtag_scan_driver

---
 rtl/firebird7_in_gate2_ijtag_pkg.sv | 15 +
 rtl/firebird7_in_gate2_ijtag_shift_reg.sv | 44 ++++
 rtl/firebird7_in_gate2_ijtag_scan_driver.sv | 117 +++++++++++
 tb/tb_firebird7_in_gate2_ijtag_scan_driver.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/firebird7_in_gate2_ijtag_pkg.sv
// Shared types and default sizing for the firebird7 gate2 IJTAG scan driver.
package firebird7_in_gate2_ijtag_pkg;

  localparam int unsigned MAX_LEN_DEF = 64;
  localparam int unsigned LEN_W_DEF   = 7;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CAPTURE = 3'd1,
    ST_SHIFT   = 3'd2,
    ST_UPDATE  = 3'd3,
    ST_DONE    = 3'd4
  } ijtag_state_e;

endpackage

// File: rtl/firebird7_in_gate2_ijtag_shift_reg.sv
// Parallel-load/serial-out data register plus indexed serial-in capture register.
module firebird7_in_gate2_ijtag_shift_reg
  import firebird7_in_gate2_ijtag_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF
) (
  input  logic               ijtag_tck,
  input  logic               ijtag_reset,
  input  logic               load,
  input  logic [MAX_LEN-1:0] load_data,
  input  logic               shift_en,
  input  logic               so,
  output logic               sdo,
  output logic [MAX_LEN-1:0] cap_data,
  output logic [LEN_W-1:0]   bit_cnt
);

  logic [MAX_LEN-1:0] data_q;

  assign sdo = data_q[0];

  // Load clears the capture image so bits beyond the scan length stay zero.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      data_q   <= '0;
      cap_data <= '0;
      bit_cnt  <= '0;
    end else if (load) begin
      data_q   <= load_data;
      cap_data <= '0;
      bit_cnt  <= '0;
    end else if (shift_en) begin
      data_q  <= {1'b0, data_q[MAX_LEN-1:1]};
      bit_cnt <= bit_cnt + LEN_W'(1);
      for (int i = 0; i < int'(MAX_LEN); i++) begin
        if (bit_cnt == LEN_W'(i)) begin
          cap_data[i] <= so;
        end
      end
    end
  end

endmodule

// File: rtl/firebird7_in_gate2_ijtag_scan_driver.sv
// IJTAG scan driver: one request runs capture, L shift cycles, update, then a response pulse.
module firebird7_in_gate2_ijtag_scan_driver
  import firebird7_in_gate2_ijtag_pkg::*;
#(
  parameter int unsigned MAX_LEN = MAX_LEN_DEF,
  parameter int unsigned LEN_W   = LEN_W_DEF
) (
  input  logic               ijtag_tck,
  input  logic               ijtag_reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [LEN_W-1:0]   req_len,
  input  logic [MAX_LEN-1:0] req_data,
  output logic               rsp_valid,
  output logic [MAX_LEN-1:0] rsp_data,
  output logic               ijtag_sel,
  output logic               ijtag_ce,
  output logic               ijtag_se,
  output logic               ijtag_ue,
  output logic               ijtag_si,
  input  logic               ijtag_so
);

  ijtag_state_e       state_q;
  ijtag_state_e       state_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_eff_c;
  logic               load_c;
  logic               shift_c;
  logic               last_shift_c;
  logic               sdo;
  logic [MAX_LEN-1:0] cap_data;
  logic [LEN_W-1:0]   bit_cnt;

  assign len_eff_c    = (req_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : req_len;
  assign shift_c      = (state_q == ST_SHIFT);
  assign last_shift_c = (LEN_W'(bit_cnt + LEN_W'(1)) == len_q);

  firebird7_in_gate2_ijtag_shift_reg #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_shift_reg (
    .ijtag_tck  (ijtag_tck),
    .ijtag_reset(ijtag_reset),
    .load       (load_c),
    .load_data  (req_data),
    .shift_en   (shift_c),
    .so         (ijtag_so),
    .sdo        (sdo),
    .cap_data   (cap_data),
    .bit_cnt    (bit_cnt)
  );

  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Requests are only looked at in IDLE; anything arriving while busy waits.
  always_comb begin
    state_d = state_q;
    load_c  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          load_c  = 1'b1;
          state_d = ST_CAPTURE;
        end
      end
      ST_CAPTURE: state_d = (len_q != '0) ? ST_SHIFT : ST_UPDATE;
      ST_SHIFT:   if (last_shift_c) state_d = ST_UPDATE;
      ST_UPDATE:  state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with the state register.
  always_ff @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      len_q     <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      ijtag_sel <= 1'b0;
      ijtag_ce  <= 1'b0;
      ijtag_se  <= 1'b0;
      ijtag_ue  <= 1'b0;
    end else begin
      if (load_c) begin
        len_q <= len_eff_c;
      end
      if (state_d == ST_DONE) begin
        rsp_data <= cap_data;
      end
      req_ready <= (state_d == ST_IDLE);
      rsp_valid <= (state_d == ST_DONE);
      ijtag_sel <= (state_d == ST_CAPTURE) || (state_d == ST_SHIFT) || (state_d == ST_UPDATE);
      ijtag_ce  <= (state_d == ST_CAPTURE);
      ijtag_se  <= (state_d == ST_SHIFT);
      ijtag_ue  <= (state_d == ST_UPDATE);
    end
  end

  // Launched on the falling edge so the network sees it stable at the rising edge.
  always_ff @(negedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      ijtag_si <= 1'b0;
    end else begin
      ijtag_si <= ijtag_se & sdo;
    end
  end

endmodule

// File: tb/tb_firebird7_in_gate2_ijtag_scan_driver.sv
// Scoreboard bench for the IJTAG scan driver against loopback and 1-bit SIB network models.
module tb_firebird7_in_gate2_ijtag_scan_driver;

  logic        ijtag_tck = 1'b0;
  logic        ijtag_reset;
  logic        req_valid;
  logic        req_ready;
  logic [6:0]  req_len;
  logic [63:0] req_data;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, ijtag_so;

  always #5 ijtag_tck = ~ijtag_tck;

  firebird7_in_gate2_ijtag_scan_driver #(.MAX_LEN(64), .LEN_W(7)) dut (
    .ijtag_tck  (ijtag_tck),
    .ijtag_reset(ijtag_reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_len    (req_len),
    .req_data   (req_data),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .ijtag_sel  (ijtag_sel),
    .ijtag_ce   (ijtag_ce),
    .ijtag_se   (ijtag_se),
    .ijtag_ue   (ijtag_ue),
    .ijtag_si   (ijtag_si),
    .ijtag_so   (ijtag_so)
  );

  // Network models: one-flop loopback, or a SIB-like shift/update bit pair.
  logic net_mode;
  logic lb_q, sib_s, sib_u;
  always @(posedge ijtag_tck or negedge ijtag_reset) begin
    if (!ijtag_reset) begin
      lb_q <= 1'b0; sib_s <= 1'b0; sib_u <= 1'b0;
    end else begin
      lb_q <= ijtag_si;
      if (ijtag_ce) sib_s <= sib_u;
      else if (ijtag_se) sib_s <= ijtag_si;
      if (ijtag_ue) sib_u <= sib_s;
    end
  end
  assign ijtag_so = net_mode ? sib_s : lb_q;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [63:0] data;
    int          len;
    int          acc_cyc;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          done_cnt = 0;
  int          last_rsp_cyc = -1;
  int          ce_cnt = 0, se_cnt = 0, ue_cnt = 0;
  bit          busy = 0;
  bit          b2b = 0;
  logic        u_exp = 1'b0;
  logic [63:0] last_rsp = '0;

  // Monitor: every falling edge, push on accept, pop and compare on response.
  always @(negedge ijtag_tck) begin
    exp_t e;
    cyc++;
    if (!ijtag_reset) begin
      sb_q.delete();
      busy     = 0;
      last_rsp = '0;
      u_exp    = 1'b0;
      check("rst_outs", {58'b0, ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, rsp_valid}, 64'h0);
      check("rst_rsp_data", rsp_data, 64'h0);
    end else begin
      check("enable_onehot0", 64'($onehot0({ijtag_ce, ijtag_se, ijtag_ue})), 64'h1);
      check("sel_match", 64'(ijtag_sel), 64'(ijtag_ce | ijtag_se | ijtag_ue));
      if (busy) begin
        ce_cnt += int'(ijtag_ce);
        se_cnt += int'(ijtag_se);
        ue_cnt += int'(ijtag_ue);
      end
      if (rsp_valid) begin
        if (sb_q.size() == 0) begin
          check("rsp_unexpected", 64'h1, 64'h0);
        end else begin
          e = sb_q.pop_front();
          check("rsp_data", rsp_data, e.data);
          check("latency", 64'(cyc - e.acc_cyc), 64'(e.len + 3));
          check("ce_cycles", 64'(ce_cnt), 64'h1);
          check("se_cycles", 64'(se_cnt), 64'(e.len));
          check("ue_cycles", 64'(ue_cnt), 64'h1);
        end
        last_rsp     = rsp_data;
        last_rsp_cyc = cyc;
        busy         = 0;
        done_cnt++;
      end else begin
        check("rsp_hold", rsp_data, last_rsp);
      end
      if (req_valid && req_ready) begin
        e.len     = (req_len > 7'd64) ? 64 : int'(req_len);
        e.data    = '0;
        e.acc_cyc = cyc;
        if (!net_mode) begin
          for (int k = 1; k < e.len; k++) e.data[k] = req_data[k-1];
        end else if (e.len >= 1) begin
          e.data[0] = u_exp;
          u_exp     = req_data[0];
        end
        if (b2b && last_rsp_cyc >= 0) check("b2b_gap", 64'(cyc - last_rsp_cyc), 64'h1);
        sb_q.push_back(e);
        busy   = 1;
        ce_cnt = 0; se_cnt = 0; ue_cnt = 0;
      end
    end
  end

  task automatic wait_accept();
    for (int i = 0; i < 50; i++) begin
      @(negedge ijtag_tck);
      if (req_ready) begin
        @(posedge ijtag_tck); #1;
        req_valid = 1'b0;
        req_data  = {$urandom, $urandom};
        req_len   = 7'($urandom);
        return;
      end
    end
    check("accept_timeout", 64'h0, 64'h1);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int start);
    for (int i = 0; i < 300; i++) begin
      @(negedge ijtag_tck);
      if (done_cnt != start) return;
    end
    check("scan_timeout", 64'h0, 64'h1);
  endtask

  task automatic do_scan(input logic [6:0] len, input logic [63:0] data);
    int start;
    start = done_cnt;
    @(posedge ijtag_tck); #1;
    req_len   = len;
    req_data  = data;
    req_valid = 1'b1;
    wait_accept();
    wait_done(start);
  endtask

  initial begin
    int start;
    int n;
    ijtag_reset = 1'b0;
    req_valid   = 1'b0;
    req_len     = '0;
    req_data    = '0;
    net_mode    = 1'b1;
    repeat (3) @(posedge ijtag_tck);
    #2 ijtag_reset = 1'b1;
    @(negedge ijtag_tck);
    check("reset_ready", 64'(req_ready), 64'h1);
    check("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    check("reset_rsp_data", rsp_data, 64'h0);

    // SIB network: first scan reads the reset value, the repeat reads back the update.
    do_scan(7'd1, 64'h1);
    check("sib_first", 64'(rsp_data[0]), 64'h0);
    do_scan(7'd1, 64'h1);
    check("sib_repeat", 64'(rsp_data[0]), 64'h1);
    do_scan(7'd1, 64'h0);
    do_scan(7'd1, 64'h0);
    check("sib_clear", 64'(rsp_data[0]), 64'h0);

    net_mode = 1'b0;
    do_scan(7'd8, 64'hA5);
    check("lb_a5", rsp_data, 64'h4A);
    do_scan(7'd0, {$urandom, $urandom});
    check("len0_data", rsp_data, 64'h0);
    do_scan(7'd100, {$urandom, $urandom});
    do_scan(7'd64, '1);
    check("len64_ones", rsp_data, 64'hFFFF_FFFF_FFFF_FFFE);
    for (int i = 0; i < 4; i++) do_scan(7'($urandom_range(1, 64)), {$urandom, $urandom});

    // Abort in shift cycle 5 of a 16-bit scan.
    start = done_cnt;
    @(posedge ijtag_tck); #1;
    req_len = 7'd16; req_data = {$urandom, $urandom}; req_valid = 1'b1;
    wait_accept();
    n = 0;
    for (int i = 0; i < 40 && n < 6; i++) begin
      @(posedge ijtag_tck); #2;
      if (ijtag_se) n++;
    end
    check("abort_reached_shift5", 64'(n), 64'h6);
    ijtag_reset = 1'b0;
    #1;
    check("abort_outs", {58'b0, ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si, rsp_valid}, 64'h0);
    check("abort_no_ue", 64'(ue_cnt), 64'h0);
    repeat (3) @(posedge ijtag_tck);
    #2 ijtag_reset = 1'b1;
    repeat (5) @(posedge ijtag_tck);
    check("abort_no_rsp", 64'(done_cnt), 64'(start));
    check("ready_after_rst", 64'(req_ready), 64'h1);
    do_scan(7'd8, 64'hA5);
    check("post_abort_a5", rsp_data, 64'h4A);

    // Continuous request: scans must follow each other with one IDLE cycle.
    start = done_cnt;
    @(posedge ijtag_tck); #1;
    last_rsp_cyc = -1;
    b2b       = 1;
    req_len   = 7'd4;
    req_data  = {$urandom, $urandom};
    req_valid = 1'b1;
    for (int i = 0; i < 300 && done_cnt < start + 3; i++) @(negedge ijtag_tck);
    check("b2b_count", 64'(done_cnt >= start + 3), 64'h1);
    @(posedge ijtag_tck); #1;
    req_valid = 1'b0;
    for (int i = 0; i < 100 && !(sb_q.size() == 0 && req_ready); i++) @(negedge ijtag_tck);
    b2b = 0;

    repeat (5) @(negedge ijtag_tck);
    check("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
